// File: rtl/tlb_sv32_plru.sv
// Fully-associative Sv32 TLB with tree pseudo-LRU replacement.
// Lookups are combinational. Refills and SFENCE.VMA flushes commit on the rising edge.
module tlb_sv32_plru #(
    parameter int TLB_ENTRIES = 4,
    parameter int ASID_WIDTH  = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [ASID_WIDTH-1:0]  asid_to_be_flushed_i,
    input  logic [31:0]            vaddr_to_be_flushed_i,
    input  logic                   update_valid_i,
    input  logic                   update_is_4M_i,
    input  logic [19:0]            update_vpn_i,
    input  logic [ASID_WIDTH-1:0]  update_asid_i,
    input  logic [31:0]            update_content_i,
    input  logic                   lu_access_i,
    input  logic [ASID_WIDTH-1:0]  lu_asid_i,
    input  logic [31:0]            lu_vaddr_i,
    output logic                   lu_hit_o,
    output logic [31:0]            lu_content_o,
    output logic                   lu_is_4M_o,
    output logic [TLB_ENTRIES-1:0] valid_o
);

    localparam int IDX_W  = $clog2(TLB_ENTRIES);
    localparam int TREE_W = TLB_ENTRIES - 1;

    typedef struct packed {
        logic                  is_4m;
        logic [9:0]            vpn1;
        logic [9:0]            vpn0;
        logic [ASID_WIDTH-1:0] asid;
        logic [31:0]           content;
    } entry_t;

    entry_t                 entry_q [TLB_ENTRIES];
    entry_t                 entry_d [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] valid_q, valid_d;
    logic [TREE_W-1:0]      plru_q, plru_d;

    logic [TLB_ENTRIES-1:0] lu_match;
    logic [TLB_ENTRIES-1:0] upd_match;
    logic [TLB_ENTRIES-1:0] flush_match;
    logic                   lu_hit;
    logic [IDX_W-1:0]       lu_idx;
    logic [IDX_W-1:0]       upd_target;
    logic                   unused_bits;

    // The page offset plays no part in translation.
    assign unused_bits = ^lu_vaddr_i[11:0];

    // Mark the path to an entry so every tree node points at the other half.
    function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] tree,
                                                     input logic [IDX_W-1:0]  idx);
        logic [TREE_W-1:0] t;
        logic [IDX_W-1:0]  sh;
        logic              dir;
        int                node;
        t    = tree;
        node = 0;
        for (int lvl = 0; lvl < IDX_W; lvl++) begin
            sh  = idx >> (IDX_W - 1 - lvl);
            dir = sh[0];
            for (int n = 0; n < TREE_W; n++) begin
                if (n == node) t[n] = ~dir;
            end
            node = 2 * node + 1 + int'(dir);
        end
        return t;
    endfunction

    // Follow the tree bits from the root; a 0 bit steers towards the lower index.
    function automatic logic [IDX_W-1:0] plru_victim(input logic [TREE_W-1:0] tree);
        logic [IDX_W-1:0] v;
        logic             b;
        int               node;
        v    = '0;
        node = 0;
        for (int lvl = 0; lvl < IDX_W; lvl++) begin
            b = 1'b0;
            for (int n = 0; n < TREE_W; n++) begin
                if (n == node) b = tree[n];
            end
            v    = (v << 1) | IDX_W'(b);
            node = 2 * node + 1 + int'(b);
        end
        return v;
    endfunction

    // Per-entry compare against the lookup, the refill tag and the flush request.
    always_comb begin
        lu_match    = '0;
        upd_match   = '0;
        flush_match = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            lu_match[i] = lu_access_i && valid_q[i]
                        && ((entry_q[i].asid == lu_asid_i) || entry_q[i].content[5])
                        && (entry_q[i].vpn1 == lu_vaddr_i[31:22])
                        && (entry_q[i].is_4m || (entry_q[i].vpn0 == lu_vaddr_i[21:12]));

            upd_match[i] = valid_q[i]
                         && (entry_q[i].is_4m == update_is_4M_i)
                         && (entry_q[i].vpn1 == update_vpn_i[19:10])
                         && (update_is_4M_i || (entry_q[i].vpn0 == update_vpn_i[9:0]))
                         && (entry_q[i].asid == update_asid_i);

            if (asid_to_be_flushed_i == '0) begin
                if (vaddr_to_be_flushed_i == '0) begin
                    flush_match[i] = 1'b1;
                end else begin
                    flush_match[i] = (entry_q[i].vpn1 == vaddr_to_be_flushed_i[31:22])
                        && (entry_q[i].is_4m || (entry_q[i].vpn0 == vaddr_to_be_flushed_i[21:12]));
                end
            end else begin
                flush_match[i] = !entry_q[i].content[5]
                    && (entry_q[i].asid == asid_to_be_flushed_i)
                    && ((vaddr_to_be_flushed_i == '0)
                        || ((entry_q[i].vpn1 == vaddr_to_be_flushed_i[31:22])
                            && (entry_q[i].is_4m || (entry_q[i].vpn0 == vaddr_to_be_flushed_i[21:12]))));
            end
        end
    end

    // Lowest matching index wins; scanning downwards leaves it as the final pick.
    always_comb begin
        lu_hit = 1'b0;
        lu_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (lu_match[i]) begin
                lu_hit = 1'b1;
                lu_idx = IDX_W'(i);
            end
        end
    end

    // Refill target: same tag in place, else lowest free slot, else the PLRU victim.
    always_comb begin
        logic found_same;
        logic found_free;
        logic [IDX_W-1:0] same_idx;
        logic [IDX_W-1:0] free_idx;
        found_same = 1'b0;
        found_free = 1'b0;
        same_idx   = '0;
        free_idx   = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (upd_match[i]) begin
                found_same = 1'b1;
                same_idx   = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                found_free = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        if (found_same)      upd_target = same_idx;
        else if (found_free) upd_target = free_idx;
        else                 upd_target = plru_victim(plru_q);
    end

    // Next state: lookup touch first, then a flush or (if no flush) the refill.
    always_comb begin
        valid_d = valid_q;
        plru_d  = plru_q;
        for (int i = 0; i < TLB_ENTRIES; i++) entry_d[i] = entry_q[i];

        if (lu_hit) plru_d = plru_touch(plru_d, lu_idx);

        if (flush_i) begin
            valid_d = valid_q & ~flush_match;
        end else if (update_valid_i) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                if (IDX_W'(i) == upd_target) begin
                    valid_d[i]         = 1'b1;
                    entry_d[i].is_4m   = update_is_4M_i;
                    entry_d[i].vpn1    = update_vpn_i[19:10];
                    entry_d[i].vpn0    = update_vpn_i[9:0];
                    entry_d[i].asid    = update_asid_i;
                    entry_d[i].content = update_content_i;
                end
            end
            plru_d = plru_touch(plru_d, upd_target);
        end
    end

    // State registers, cleared asynchronously so a pending refill or flush is discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            plru_q  <= '0;
            for (int i = 0; i < TLB_ENTRIES; i++) entry_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            plru_q  <= plru_d;
            for (int i = 0; i < TLB_ENTRIES; i++) entry_q[i] <= entry_d[i];
        end
    end

    assign lu_hit_o     = lu_hit;
    assign lu_content_o = lu_hit ? entry_q[lu_idx].content : 32'h0;
    assign lu_is_4M_o   = lu_hit ? entry_q[lu_idx].is_4m : 1'b0;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_tlb_sv32_plru.sv
// Self-checking bench for tlb_sv32_plru: a behavioural TLB model is compared every
// cycle, and hand-computed expectations pin the key scenarios.
module tb_tlb_sv32_plru;

    localparam int N   = 4;
    localparam int AW  = 1;
    localparam int LOG = 2;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [AW-1:0] flush_asid;
    logic [31:0]   flush_vaddr;
    logic          upd_valid;
    logic          upd_4m;
    logic [19:0]   upd_vpn;
    logic [AW-1:0] upd_asid;
    logic [31:0]   upd_pte;
    logic          lu_access;
    logic [AW-1:0] lu_asid;
    logic [31:0]   lu_vaddr;
    logic          lu_hit;
    logic [31:0]   lu_content;
    logic          lu_is_4m;
    logic [N-1:0]  valid;

    int vectors    = 0;
    int miscompares = 0;

    tlb_sv32_plru #(.TLB_ENTRIES(N), .ASID_WIDTH(AW)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .flush_i               (flush),
        .asid_to_be_flushed_i  (flush_asid),
        .vaddr_to_be_flushed_i (flush_vaddr),
        .update_valid_i        (upd_valid),
        .update_is_4M_i        (upd_4m),
        .update_vpn_i          (upd_vpn),
        .update_asid_i         (upd_asid),
        .update_content_i      (upd_pte),
        .lu_access_i           (lu_access),
        .lu_asid_i             (lu_asid),
        .lu_vaddr_i            (lu_vaddr),
        .lu_hit_o              (lu_hit),
        .lu_content_o          (lu_content),
        .lu_is_4M_o            (lu_is_4m),
        .valid_o               (valid)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        bit          is4m;
        bit [19:0]   vpn;
        bit [AW-1:0] asid;
        bit [31:0]   pte;
    } ment_t;

    ment_t m [N];
    // vict_upper[l][g]: within the g-th group of size N>>l, the victim lies in the upper half.
    bit    vict_upper [LOG][N];

    function automatic void modelReset();
        for (int i = 0; i < N; i++) m[i] = '{default: 0};
        for (int l = 0; l < LOG; l++)
            for (int g = 0; g < N; g++) vict_upper[l][g] = 1'b0;
    endfunction

    function automatic int modelVictim();
        int idx = 0;
        for (int l = 0; l < LOG; l++) idx = idx * 2 + (vict_upper[l][idx] ? 1 : 0);
        return idx;
    endfunction

    function automatic void modelTouch(input int e);
        for (int l = 0; l < LOG; l++) begin
            int g    = e >> (LOG - l);
            int half = (e >> (LOG - 1 - l)) & 1;
            vict_upper[l][g] = (half == 0);
        end
    endfunction

    function automatic int modelLookup(input bit acc, input bit [AW-1:0] a, input bit [31:0] va);
        if (!acc) return -1;
        for (int i = 0; i < N; i++) begin
            if (m[i].v && (m[i].asid == a || m[i].pte[5]) && m[i].vpn[19:10] == va[31:22]
                && (m[i].is4m || m[i].vpn[9:0] == va[21:12])) return i;
        end
        return -1;
    endfunction

    function automatic void modelStep();
        int hit_i;
        int vic;
        int tgt;
        hit_i = modelLookup(lu_access, lu_asid, lu_vaddr);
        vic   = modelVictim();
        if (hit_i >= 0) modelTouch(hit_i);
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                bit vm;
                bit am;
                vm = (m[i].vpn[19:10] == flush_vaddr[31:22])
                     && (m[i].is4m || m[i].vpn[9:0] == flush_vaddr[21:12]);
                am = (m[i].asid == flush_asid) && !m[i].pte[5];
                if (flush_asid == 0) begin
                    if (flush_vaddr == 0 || vm) m[i].v = 1'b0;
                end else begin
                    if (am && (flush_vaddr == 0 || vm)) m[i].v = 1'b0;
                end
            end
        end else if (upd_valid) begin
            tgt = -1;
            for (int i = 0; i < N && tgt < 0; i++)
                if (m[i].v && m[i].is4m == upd_4m && m[i].asid == upd_asid
                    && m[i].vpn[19:10] == upd_vpn[19:10]
                    && (upd_4m || m[i].vpn[9:0] == upd_vpn[9:0])) tgt = i;
            for (int i = 0; i < N && tgt < 0; i++)
                if (!m[i].v) tgt = i;
            if (tgt < 0) tgt = vic;
            m[tgt] = '{v: 1'b1, is4m: upd_4m, vpn: upd_vpn, asid: upd_asid, pte: upd_pte};
            modelTouch(tgt);
        end
    endfunction

    // Compare process: check DUT against the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        int          h;
        bit          e_hit;
        bit [31:0]   e_pte;
        bit          e_4m;
        bit [N-1:0]  e_valid;
        if (!rst_n) modelReset();
        h       = modelLookup(lu_access, lu_asid, lu_vaddr);
        e_hit   = (h >= 0);
        e_pte   = (h >= 0) ? m[h].pte : 32'h0;
        e_4m    = (h >= 0) ? m[h].is4m : 1'b0;
        for (int i = 0; i < N; i++) e_valid[i] = m[i].v;
        vectors++;
        if (lu_hit !== e_hit || lu_content !== e_pte || lu_is_4m !== e_4m || valid !== e_valid) begin
            miscompares++;
            $display("[TB] FAIL model t=%0t: got hit=%0b pte=%08h 4M=%0b valid=%b, want hit=%0b pte=%08h 4M=%0b valid=%b",
                     $time, lu_hit, lu_content, lu_is_4m, valid, e_hit, e_pte, e_4m, e_valid);
        end
        if (rst_n) modelStep();
    end

    // ---------------- stimulus and literal checks ----------------
    task automatic applyStimulus(input bit f, input bit [AW-1:0] fa, input bit [31:0] fv,
                                 input bit u, input bit u4m, input bit [19:0] uvpn,
                                 input bit [AW-1:0] uasid, input bit [31:0] upte,
                                 input bit acc, input bit [AW-1:0] la, input bit [31:0] lva);
        @(posedge clk);
        #1;
        flush = f;     flush_asid = fa;   flush_vaddr = fv;
        upd_valid = u; upd_4m = u4m;      upd_vpn = uvpn;   upd_asid = uasid; upd_pte = upte;
        lu_access = acc; lu_asid = la;    lu_vaddr = lva;
    endtask

    task automatic doUpdate(input bit [19:0] vpn, input bit [AW-1:0] a, input bit [31:0] pte, input bit is4m);
        applyStimulus(0, 0, 0, 1, is4m, vpn, a, pte, 0, 0, 0);
    endtask

    task automatic doFlush(input bit [AW-1:0] a, input bit [31:0] v);
        applyStimulus(1, a, v, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doLookup(input bit [31:0] va, input bit [AW-1:0] a);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, a, va);
        #2;
    endtask

    task automatic checkOutput(input string name, input bit eh, input bit [31:0] ec, input bit e4);
        vectors++;
        if (lu_hit !== eh || lu_content !== ec || lu_is_4m !== e4) begin
            miscompares++;
            $display("[TB] FAIL %s: got hit=%0b pte=%08h 4M=%0b, want hit=%0b pte=%08h 4M=%0b",
                     name, lu_hit, lu_content, lu_is_4m, eh, ec, e4);
        end
    endtask

    task automatic checkValid(input string name, input bit [N-1:0] ev);
        vectors++;
        if (valid !== ev) begin
            miscompares++;
            $display("[TB] FAIL %s: got valid=%b, want valid=%b", name, valid, ev);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 0; flush_asid = 0; flush_vaddr = 0;
        upd_valid = 0; upd_4m = 0; upd_vpn = 0; upd_asid = 0; upd_pte = 0;
        lu_access = 0; lu_asid = 0; lu_vaddr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and a first translation
        doLookup(32'h12345000, 1);
        checkOutput("reset_lookup", 0, 32'h0, 0);
        checkValid("reset_valid", 4'b0000);
        doUpdate(20'h12345, 1, 32'h000ABCCF, 0);
        doLookup(32'h12345678, 1);
        checkOutput("hit_4k", 1, 32'h000ABCCF, 0);
        doLookup(32'h12345678, 0);
        checkOutput("asid_miss", 0, 32'h0, 0);

        // Superpage: any vpn0 under vpn1 0x048 hits
        doUpdate({10'h048, 10'h000}, 1, 32'h0480000F, 1);
        doLookup(32'h12000000, 1);
        checkOutput("hit_4m_lo", 1, 32'h0480000F, 1);
        doLookup(32'h123FF000, 1);
        checkOutput("hit_4m_hi", 1, 32'h0480000F, 1);
        doLookup(32'h12345678, 1);
        checkOutput("multi_match_lowest", 1, 32'h000ABCCF, 0);

        // Fill, PLRU eviction and in-place refresh
        doReset();
        for (int k = 1; k <= 4; k++) doUpdate(20'(k), 1, (32'(k) << 12) | 32'hF, 0);
        doLookup(32'h00001000, 1);
        checkOutput("fill_hit_vpn1", 1, 32'h0000100F, 0);
        checkValid("fill_valid", 4'b1111);
        doUpdate(20'h5, 1, 32'h0000500F, 0);
        doLookup(32'h00003000, 1);
        checkOutput("evicted_vpn3", 0, 32'h0, 0);
        doLookup(32'h00005000, 1);
        checkOutput("new_vpn5", 1, 32'h0000500F, 0);
        doLookup(32'h00001000, 1);
        checkOutput("kept_vpn1", 1, 32'h0000100F, 0);
        doUpdate(20'h4, 1, 32'h0044400F, 0);
        doLookup(32'h00004000, 1);
        checkOutput("refresh_vpn4", 1, 32'h0044400F, 0);
        doLookup(32'h00002000, 1);
        checkOutput("refresh_kept_vpn2", 1, 32'h0000200F, 0);
        checkValid("refresh_valid", 4'b1111);

        // Global bit and flush variants
        doReset();
        doUpdate(20'h00100, 1, 32'h0000012F, 0);
        doUpdate(20'h00200, 1, 32'h0000020F, 0);
        doLookup(32'h00100000, 0);
        checkOutput("global_any_asid", 1, 32'h0000012F, 0);
        doFlush(1, 32'h0);
        doLookup(32'h00200000, 1);
        checkOutput("flush_asid_nonglobal", 0, 32'h0, 0);
        checkValid("flush_asid_valid", 4'b0001);
        doFlush(0, 32'h0);
        doLookup(32'h00100000, 1);
        checkValid("flush_all_valid", 4'b0000);
        doUpdate(20'h00100, 1, 32'h0000012F, 0);
        doUpdate(20'h00300, 1, 32'h0000030F, 0);
        doFlush(0, 32'h00100000);
        doLookup(32'h00300000, 1);
        checkValid("flush_vaddr_global", 4'b0010);
        doFlush(1, 32'h00300000);
        doLookup(32'h00300000, 1);
        checkValid("flush_both", 4'b0000);

        // Flush and refill together: refill dropped
        applyStimulus(1, 0, 0, 1, 0, 20'h00777, 1, 32'h0077700F, 0, 0, 0);
        doLookup(32'h00777000, 1);
        checkOutput("flush_beats_update", 0, 32'h0, 0);

        // Reset asserted during a refill discards it
        @(posedge clk);
        #1;
        upd_valid = 1; upd_vpn = 20'h00888; upd_asid = 1; upd_pte = 32'h0088800F; upd_4m = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        upd_valid = 0;
        rst_n = 1'b1;
        #2;
        checkValid("reset_mid_update", 4'b0000);

        // Mixed sequence over a small address pool, checked against the model
        for (int k = 0; k < 300; k++) begin
            bit [19:0] vpn;
            bit [31:0] pte;
            int        op;
            vpn = 20'(($urandom_range(0, 1) << 10) | $urandom_range(0, 3));
            pte = $urandom;
            op  = $urandom_range(0, 19);
            applyStimulus(op == 0, AW'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0) ? 32'h0 : {vpn, 12'h0},
                          op >= 8, ($urandom_range(0, 5) == 0), vpn, AW'($urandom_range(0, 1)), pte,
                          $urandom_range(0, 3) != 0, AW'($urandom_range(0, 1)),
                          {20'(($urandom_range(0, 1) << 10) | $urandom_range(0, 3)), 12'(k)});
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlb_sv32_plru.md
# tlb_sv32_plru

Parametrised fully-associative Sv32 TLB, the next generation of the 4-entry `cva6_tlb_sv32`. It adds a configurable entry count and ASID width, tree pseudo-LRU replacement, honouring of the PTE global bit, and in-place refresh of a tag that is already present. It sits between the CVA6 MMU/PTW and the ITLB/DTLB lookup paths: it answers translations in the same cycle and accepts refills and SFENCE.VMA flushes.

## Interface
- `TLB_ENTRIES`, default 4: number of entries; power of two, ≥ 2.
- `ASID_WIDTH`, default 1: ASID bits; 1..9.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `flush_i` in 1: SFENCE.VMA request, single-cycle pulse.
- `asid_to_be_flushed_i` in ASID_WIDTH: flush ASID (rs2); 0 means all ASIDs.
- `vaddr_to_be_flushed_i` in 32: flush vaddr (rs1); 0 means all addresses.
- `update_valid_i` in 1: write refill entry this cycle.
- `update_is_4M_i` in 1: refill is a 4 MiB superpage.
- `update_vpn_i` in 20: refill VPN; `[19:10]` = vpn1, `[9:0]` = vpn0.
- `update_asid_i` in ASID_WIDTH: refill ASID.
- `update_content_i` in 32: refill Sv32 PTE; bit 5 = G, `[31:10]` = PPN.
- `lu_access_i` in 1: lookup is a real access; updates PLRU on hit.
- `lu_asid_i` in ASID_WIDTH: lookup ASID.
- `lu_vaddr_i` in 32: lookup virtual address.
- `lu_hit_o` out 1: lookup hit.
- `lu_content_o` out 32: PTE of the hitting entry; 0 on miss.
- `lu_is_4M_o` out 1: the hitting entry is a superpage; 0 on miss.
- `valid_o` out TLB_ENTRIES: per-entry valid bits, for verification visibility.

## Operation
- Entry state: `valid`, `is_4M`, `vpn1[9:0]`, `vpn0[9:0]`, `asid`, `content[31:0]`.
- Entry i matches a lookup when all of the following hold:
  - `valid`
  - `asid == lu_asid_i` or `content[5]` (G) is set
  - `vpn1 == lu_vaddr_i[31:22]`
  - `is_4M` is set, or `vpn0 == lu_vaddr_i[21:12]`
- Multiple matches: the lowest index drives the outputs. This is not an error.
- Lookup is evaluated only when `lu_access_i` = 1. With `lu_access_i` = 0, all lookup outputs are 0 and PLRU is unchanged.
- Replacement state: tree PLRU with `TLB_ENTRIES-1` bits, all 0 at reset. Victim is found by following the bits: 0 means go left (lower index).
- On a lookup hit with `lu_access_i`, and on every committed update, the tree bits on the path to the touched entry are set to point away from it.
- Update target, in priority order:
  1. A valid entry with identical {vpn1, vpn0 (ignored if 4M), asid, is_4M} is overwritten in place.
  2. Otherwise, the lowest-index invalid entry.
  3. Otherwise, the PLRU victim.
- Flush (`flush_i`), using a = `asid_to_be_flushed_i` and v = `vaddr_to_be_flushed_i`:
  - a = 0, v = 0: invalidate all entries.
  - a = 0, v ≠ 0: invalidate entries whose VPN matches v (vpn1 only if 4M), including global entries.
  - a ≠ 0, v = 0: invalidate non-global entries whose asid == a.
  - a ≠ 0, v ≠ 0: invalidate non-global entries matching both v and a.
- PLRU bits are not changed by a flush.
- `flush_i` together with `update_valid_i`: the flush wins and the update is dropped.
- A lookup in a flush or update cycle sees the pre-edge state.
- A lookup hit and an update in the same cycle: PLRU applies the lookup touch first, then the update touch, so the updated entry ends up most-recent.

## Timing
- Lookup is combinational: `lu_*` outputs are valid in the same cycle as `lu_vaddr_i`/`lu_asid_i`.
- An update is visible to lookups from the cycle after `update_valid_i`.
- A flush takes effect from the cycle after `flush_i`.
- PLRU changes are visible to victim selection on the next cycle.
- Reset (asynchronous assert, synchronous-safe deassert):
  - all `valid` = 0, PLRU = 0
  - `lu_hit_o` = 0, `lu_content_o` = 0, `lu_is_4M_o` = 0, `valid_o` = 0
- Reset asserted mid-operation discards any pending update or flush in that cycle.
- No stall or handshake: every request completes in one cycle.

## Test plan
- Reset, then look up vaddr `0x12345000`, asid 1 → `lu_hit_o` = 0, `lu_content_o` = 0.
- Update vpn `0x12345`, asid 1, PTE `0x000ABCCF`; next cycle look up `0x12345678` asid 1 → hit, content `0x000ABCCF`, `is_4M` = 0. The same lookup with asid 0 → miss.
- Update a 4M entry with vpn1 `0x048`, asid 1; look up `0x12000000` and `0x123FF000` → both hit, `lu_is_4M_o` = 1.
- TLB_ENTRIES = 4:
  - Fill vpns 1–4 → `valid_o` = `4'b1111`.
  - Hit vpn 1, then update vpn 5 → entry 0 is kept; vpn 5 replaces the PLRU victim, entry 2 (vpn 3).
  - Re-update vpn 4 with a new PTE → overwritten in place, no eviction.
- Global entry (G = 1, asid 1) plus non-global entry (asid 1):
  - Flush a = 1, v = 0 → only the non-global entry is cleared.
  - Flush a = 0, v = 0 → `valid_o` = 0.
- `flush_i` and `update_valid_i` in the same cycle → the update is dropped; next-cycle lookup misses.
